// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: opcodes, ALU encodings, instruction
// field positions and the D/E control bundle.
package decode_pkg;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_AND   = 4'b0011;
  localparam logic [3:0] OP_OR    = 4'b0100;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_LOAD  = 4'b0110;
  localparam logic [3:0] OP_STORE = 4'b0111;
  localparam logic [3:0] OP_BEQ   = 4'b1000;
  localparam logic [3:0] OP_JMP   = 4'b1001;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  localparam int INSTR_W   = 17;
  localparam int REG_AW    = 4;
  localparam int OP_MSB    = 16;
  localparam int OP_LSB    = 13;
  localparam int RD_MSB    = 12;
  localparam int RD_LSB    = 9;
  localparam int RS1_MSB   = 8;
  localparam int RS1_LSB   = 5;
  localparam int RS2_MSB   = 4;
  localparam int RS2_LSB   = 1;
  localparam int IMM5_MSB  = 4;
  localparam int IMM12_MSB = 11;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic [2:0] alu_control;
  } ctrl_t;

endpackage

// File: rtl/register_file.sv
// 16-entry register file: two combinational reads, one synchronous write, r0 = 0.
// DECODE_WB_BYPASS_EN makes a same-cycle write visible on the read ports.
module register_file
  import decode_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

`ifdef DECODE_WB_BYPASS_EN
  // Write-through: the Writeback result wins over the stored value.
  assign rd1 = (ra1 == '0) ? '0 : ((we && (wa == ra1)) ? wd : regs[ra1]);
  assign rd2 = (ra2 == '0) ? '0 : ((we && (wa == ra2)) ? wd : regs[ra2]);
`else
  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];
`endif

endmodule

// File: rtl/decode.sv
// Decode pipeline stage: field decode, register read, immediate extension and
// the D/E register. Optional write-through read enabled by DECODE_WB_BYPASS_EN.
module decode
  import decode_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] InstrD,
  input  logic [11:0]        PCD,
  input  logic [11:0]        PCPlus1D,
  input  logic               StallE,
  input  logic               FlushE,
  input  logic               RegWriteW,
  input  logic [REG_AW-1:0]  RdW,
  input  logic [DATA_W-1:0]  ResultW,
  output logic [DATA_W-1:0]  RD1E,
  output logic [DATA_W-1:0]  RD2E,
  output logic [DATA_W-1:0]  ImmExtE,
  output logic [REG_AW-1:0]  Rs1E,
  output logic [REG_AW-1:0]  Rs2E,
  output logic [REG_AW-1:0]  RdE,
  output logic [11:0]        PCE,
  output logic [11:0]        PCPlus1E,
  output logic               RegWriteE,
  output logic               MemWriteE,
  output logic               MemToRegE,
  output logic               BranchE,
  output logic               JumpE,
  output logic               ALUSrcE,
  output logic [2:0]         ALUControlE
);

  function automatic logic signed [DATA_W-1:0] sext5(input logic [4:0] v);
    logic signed [4:0] s;
    s = signed'(v);
    return DATA_W'(s);
  endfunction

  function automatic logic signed [DATA_W-1:0] sext12(input logic [11:0] v);
    logic signed [11:0] s;
    s = signed'(v);
    return DATA_W'(s);
  endfunction

  // Stage p0: combinational decode and register read
  ctrl_t                    ctrl_p0;
  logic [3:0]               op_p0;
  logic [REG_AW-1:0]        rs1_p0, rs2_p0, rd_p0;
  logic signed [DATA_W-1:0] imm_p0;
  logic [DATA_W-1:0]        rd1_p0, rd2_p0;

  always_comb begin
    ctrl_p0 = '0;
    imm_p0  = '0;
    op_p0   = InstrD[OP_MSB:OP_LSB];
    rs1_p0  = InstrD[RS1_MSB:RS1_LSB];
    rs2_p0  = InstrD[RS2_MSB:RS2_LSB];
    rd_p0   = InstrD[RD_MSB:RD_LSB];
    case (op_p0)
      OP_ADD: begin ctrl_p0.reg_write = 1'b1; ctrl_p0.alu_control = ALU_ADD; end
      OP_SUB: begin ctrl_p0.reg_write = 1'b1; ctrl_p0.alu_control = ALU_SUB; end
      OP_AND: begin ctrl_p0.reg_write = 1'b1; ctrl_p0.alu_control = ALU_AND; end
      OP_OR:  begin ctrl_p0.reg_write = 1'b1; ctrl_p0.alu_control = ALU_OR;  end
      OP_ADDI: begin
        ctrl_p0.reg_write = 1'b1;
        ctrl_p0.alu_src   = 1'b1;
        imm_p0            = sext5(InstrD[IMM5_MSB:0]);
      end
      OP_LOAD: begin
        ctrl_p0.reg_write  = 1'b1;
        ctrl_p0.mem_to_reg = 1'b1;
        ctrl_p0.alu_src    = 1'b1;
        imm_p0             = sext5(InstrD[IMM5_MSB:0]);
      end
      // STORE and BEQ carry their second source in the rd field
      OP_STORE: begin
        ctrl_p0.mem_write = 1'b1;
        ctrl_p0.alu_src   = 1'b1;
        rs2_p0            = InstrD[RD_MSB:RD_LSB];
        rd_p0             = '0;
        imm_p0            = sext5(InstrD[IMM5_MSB:0]);
      end
      OP_BEQ: begin
        ctrl_p0.branch      = 1'b1;
        ctrl_p0.alu_control = ALU_SUB;
        rs2_p0              = InstrD[RD_MSB:RD_LSB];
        rd_p0               = '0;
        imm_p0              = sext5(InstrD[IMM5_MSB:0]);
      end
      OP_JMP: begin
        ctrl_p0.jump = 1'b1;
        imm_p0       = sext12(InstrD[IMM12_MSB:0]);
      end
      default: ;
    endcase
  end

  register_file #(.DATA_W(DATA_W), .NREGS(NREGS)) u_register_file (
    .clk   (clk),
    .reset (reset),
    .we    (RegWriteW),
    .wa    (RdW),
    .wd    (ResultW),
    .ra1   (rs1_p0),
    .ra2   (rs2_p0),
    .rd1   (rd1_p0),
    .rd2   (rd2_p0)
  );

  // Stage p1: D/E register (flush beats stall)
  ctrl_t                    ctrl_p1;
  logic [REG_AW-1:0]        rs1_p1, rs2_p1, rd_p1;
  logic signed [DATA_W-1:0] imm_p1;
  logic [DATA_W-1:0]        rd1_p1, rd2_p1;
  logic [11:0]              pc_p1, pc1_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset || FlushE) begin
      ctrl_p1 <= '0;
      rs1_p1  <= '0;
      rs2_p1  <= '0;
      rd_p1   <= '0;
      imm_p1  <= '0;
      rd1_p1  <= '0;
      rd2_p1  <= '0;
      pc_p1   <= '0;
      pc1_p1  <= '0;
    end else if (!StallE) begin
      ctrl_p1 <= ctrl_p0;
      rs1_p1  <= rs1_p0;
      rs2_p1  <= rs2_p0;
      rd_p1   <= rd_p0;
      imm_p1  <= imm_p0;
      rd1_p1  <= rd1_p0;
      rd2_p1  <= rd2_p0;
      pc_p1   <= PCD;
      pc1_p1  <= PCPlus1D;
    end
  end

  assign RD1E        = rd1_p1;
  assign RD2E        = rd2_p1;
  assign ImmExtE     = imm_p1;
  assign Rs1E        = rs1_p1;
  assign Rs2E        = rs2_p1;
  assign RdE         = rd_p1;
  assign PCE         = pc_p1;
  assign PCPlus1E    = pc1_p1;
  assign RegWriteE   = ctrl_p1.reg_write;
  assign MemWriteE   = ctrl_p1.mem_write;
  assign MemToRegE   = ctrl_p1.mem_to_reg;
  assign BranchE     = ctrl_p1.branch;
  assign JumpE       = ctrl_p1.jump;
  assign ALUSrcE     = ctrl_p1.alu_src;
  assign ALUControlE = ctrl_p1.alu_control;

endmodule

// File: tb/tb_decode.sv
// Self-checking bench for decode: directed scenarios plus a randomized run
// against a behavioural register-file/decode model.
module tb_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic [16:0] InstrD;
  logic [11:0] PCD, PCPlus1D;
  logic        StallE, FlushE, RegWriteW;
  logic [3:0]  RdW;
  logic [15:0] ResultW;
  logic [15:0] RD1E, RD2E, ImmExtE;
  logic [3:0]  Rs1E, Rs2E, RdE;
  logic [11:0] PCE, PCPlus1E;
  logic        RegWriteE, MemWriteE, MemToRegE, BranchE, JumpE, ALUSrcE;
  logic [2:0]  ALUControlE;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [15:0] ref_regs [16];

  decode #(.DATA_W(16), .NREGS(16)) dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .PCD(PCD), .PCPlus1D(PCPlus1D),
    .StallE(StallE), .FlushE(FlushE), .RegWriteW(RegWriteW), .RdW(RdW),
    .ResultW(ResultW), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .PCE(PCE), .PCPlus1E(PCPlus1E),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemToRegE(MemToRegE),
    .BranchE(BranchE), .JumpE(JumpE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16:0] mk(input logic [3:0] op, rd, rs1, rs2);
    return {op, rd, rs1, rs2, 1'b0};
  endfunction

  function automatic logic [92:0] obs();
    return {RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, PCE, PCPlus1E,
            RegWriteE, MemWriteE, MemToRegE, BranchE, JumpE, ALUSrcE, ALUControlE};
  endfunction

  function automatic logic [15:0] model_read(input logic [3:0] a, input logic we,
                                             input logic [3:0] wa, input logic [15:0] wd);
    if (a == 0) return 16'h0;
`ifdef DECODE_WB_BYPASS_EN
    if (we && wa == a) return wd;
`endif
    return ref_regs[a];
  endfunction

  // Expected E-stage values for one instruction, from the opcode table
  function automatic logic [92:0] model(input logic [16:0] ins, input logic [11:0] pc, pc1,
                                        input logic we, input logic [3:0] wa,
                                        input logic [15:0] wd);
    int op, v;
    logic [5:0] ctl;
    logic [2:0] alu;
    logic [3:0] rs1, rs2, rd;
    logic [15:0] imm;
    op  = int'(ins[16:13]);
    ctl = 6'b0;
    alu = 3'b000;
    imm = 16'h0;
    case (op)
      1, 2, 3, 4: begin ctl = 6'b100000; alu = 3'(op - 1); end
      5: ctl = 6'b100001;
      6: ctl = 6'b101001;
      7: ctl = 6'b010001;
      8: begin ctl = 6'b000100; alu = 3'b001; end
      9: ctl = 6'b000010;
      default: ;
    endcase
    if (op >= 5 && op <= 8) begin
      v = int'(ins[4:0]);
      if (v >= 16) v -= 32;
      imm = 16'(v);
    end else if (op == 9) begin
      v = int'(ins[11:0]);
      if (v >= 2048) v -= 4096;
      imm = 16'(v);
    end
    rs1 = ins[8:5];
    if (op == 7 || op == 8) begin rs2 = ins[12:9]; rd = 4'd0; end
    else begin rs2 = ins[4:1]; rd = ins[12:9]; end
    return {model_read(rs1, we, wa, wd), model_read(rs2, we, wa, wd), imm,
            rs1, rs2, rd, pc, pc1, ctl, alu};
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    InstrD = '0; PCD = '0; PCPlus1D = '0; StallE = 0; FlushE = 0;
    RegWriteW = 0; RdW = '0; ResultW = '0;
    tick(); tick();
    #2 reset = 1'b1;
    tick();
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [15:0] d);
    RegWriteW = 1; RdW = a; ResultW = d;
    tick();
    RegWriteW = 0;
  endtask

  task automatic test_reset();
    write_reg(4'd5, 16'h1234);
    InstrD = mk(4'b0001, 4'd3, 4'd1, 4'd2); PCD = 12'h010; PCPlus1D = 12'h011;
    tick();
    total_cnt++;
    if (RegWriteE !== 1'b1) $display("FAIL reset_pre RegWriteE got %b want 1", RegWriteE);
    else pass_cnt++;
    #2 reset = 1'b0;
    #1;
    total_cnt++;
    if (obs() !== 93'h0) $display("FAIL reset_async E outputs got %h want 0", obs());
    else pass_cnt++;
    #3 reset = 1'b1;
    InstrD = mk(4'b0001, 4'd6, 4'd5, 4'd5);
    tick();
    total_cnt++;
    if (RD1E !== 16'h0 || RD2E !== 16'h0 || RdE !== 4'd6 || RegWriteE !== 1'b1)
      $display("FAIL reset_rf r5 RD1E=%h RD2E=%h RdE=%0d RegWriteE=%b want 0 0 6 1",
               RD1E, RD2E, RdE, RegWriteE);
    else pass_cnt++;
  endtask

  task automatic test_add();
    write_reg(4'd1, 16'd5);
    write_reg(4'd2, 16'd7);
    InstrD = mk(4'b0001, 4'd3, 4'd1, 4'd2);
    tick();
    total_cnt++;
    if (RD1E !== 16'd5 || RD2E !== 16'd7 || RdE !== 4'd3)
      $display("FAIL add_data RD1E=%h RD2E=%h RdE=%0d want 5 7 3", RD1E, RD2E, RdE);
    else pass_cnt++;
    total_cnt++;
    if (RegWriteE !== 1'b1 || ALUControlE !== 3'b000 || ALUSrcE !== 1'b0)
      $display("FAIL add_ctrl RegWrite=%b ALU=%b ALUSrc=%b want 1 000 0",
               RegWriteE, ALUControlE, ALUSrcE);
    else pass_cnt++;
  endtask

  task automatic test_beq();
    InstrD = {4'b1000, 4'd4, 4'd2, 5'b11101};
    tick();
    total_cnt++;
    if (ImmExtE !== 16'hFFFD || BranchE !== 1'b1 || ALUControlE !== 3'b001)
      $display("FAIL beq_ctrl Imm=%h Branch=%b ALU=%b want FFFD 1 001",
               ImmExtE, BranchE, ALUControlE);
    else pass_cnt++;
    total_cnt++;
    if (RegWriteE !== 1'b0 || Rs2E !== 4'd4 || RdE !== 4'd0 || Rs1E !== 4'd2 || RD1E !== 16'd7)
      $display("FAIL beq_regs RegWrite=%b Rs1=%0d Rs2=%0d Rd=%0d RD1=%h want 0 2 4 0 0007",
               RegWriteE, Rs1E, Rs2E, RdE, RD1E);
    else pass_cnt++;
  endtask

  task automatic test_wb_read();
    logic [15:0] want;
    write_reg(4'd4, 16'h0011);
    InstrD = mk(4'b0001, 4'd1, 4'd4, 4'd0);
    RegWriteW = 1; RdW = 4'd4; ResultW = 16'h00AA;
`ifdef DECODE_WB_BYPASS_EN
    want = 16'h00AA;
`else
    want = 16'h0011;
`endif
    tick();
    RegWriteW = 0;
    total_cnt++;
    if (RD1E !== want) $display("FAIL wb_same_cycle RD1E got %h want %h", RD1E, want);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (RD1E !== 16'h00AA) $display("FAIL wb_next_cycle RD1E got %h want 00aa", RD1E);
    else pass_cnt++;
  endtask

  task automatic test_pipeline_ctrl();
    write_reg(4'd1, 16'd5);
    InstrD = {4'b0101, 4'd7, 4'd1, 5'b10110}; PCD = 12'h123; PCPlus1D = 12'h124;
    tick();
    total_cnt++;
    if (RD1E !== 16'd5 || ImmExtE !== 16'hFFF6 || RdE !== 4'd7 || PCE !== 12'h123 ||
        PCPlus1E !== 12'h124 || RegWriteE !== 1'b1 || ALUSrcE !== 1'b1)
      $display("FAIL addi_load RD1=%h Imm=%h Rd=%0d PC=%h PC1=%h RW=%b AS=%b want 0005 fff6 7 123 124 1 1",
               RD1E, ImmExtE, RdE, PCE, PCPlus1E, RegWriteE, ALUSrcE);
    else pass_cnt++;
    StallE = 1;
    InstrD = {4'b1001, 1'b0, 12'h055}; PCD = 12'h200; PCPlus1D = 12'h201;
    RegWriteW = 1; RdW = 4'd1; ResultW = 16'h0099;
    for (int c = 0; c < 2; c++) begin
      tick();
      RegWriteW = 0;
      total_cnt++;
      if (RD1E !== 16'd5 || ImmExtE !== 16'hFFF6 || RdE !== 4'd7 || PCE !== 12'h123 ||
          RegWriteE !== 1'b1 || JumpE !== 1'b0)
        $display("FAIL stall_hold cycle %0d RD1=%h Imm=%h Rd=%0d PC=%h RW=%b J=%b want 0005 fff6 7 123 1 0",
                 c, RD1E, ImmExtE, RdE, PCE, RegWriteE, JumpE);
      else pass_cnt++;
    end
    FlushE = 1;
    tick();
    total_cnt++;
    if (obs() !== 93'h0) $display("FAIL flush_over_stall E outputs got %h want 0", obs());
    else pass_cnt++;
    StallE = 0; FlushE = 0;
    InstrD = mk(4'b0001, 4'd2, 4'd1, 4'd0);
    tick();
    total_cnt++;
    if (RD1E !== 16'h0099) $display("FAIL stall_write r1 got %h want 0099", RD1E);
    else pass_cnt++;
  endtask

  task automatic test_corners();
    write_reg(4'd0, 16'hFFFF);
    InstrD = mk(4'b0001, 4'd2, 4'd0, 4'd0);
    tick();
    total_cnt++;
    if (RD1E !== 16'h0 || RD2E !== 16'h0) $display("FAIL r0_read RD1E=%h RD2E=%h want 0 0", RD1E, RD2E);
    else pass_cnt++;
    InstrD = 17'h1FFFF;
    tick();
    total_cnt++;
    if ({RegWriteE, MemWriteE, MemToRegE, BranchE, JumpE, ALUSrcE, ALUControlE} !== 9'h0 ||
        ImmExtE !== 16'h0)
      $display("FAIL illegal_op ctrl=%b imm=%h want 0 0",
               {RegWriteE, MemWriteE, MemToRegE, BranchE, JumpE, ALUSrcE, ALUControlE}, ImmExtE);
    else pass_cnt++;
    InstrD = {4'b1001, 1'b0, 12'h800};
    tick();
    total_cnt++;
    if (ImmExtE !== 16'hF800 || JumpE !== 1'b1 || RegWriteE !== 1'b0)
      $display("FAIL jmp_imm Imm=%h Jump=%b RW=%b want f800 1 0", ImmExtE, JumpE, RegWriteE);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [92:0] cand, exp_e;
    do_reset();
    for (int i = 0; i < 16; i++) ref_regs[i] = 16'h0;
    exp_e = '0;
    for (int n = 0; n < 400; n++) begin
      InstrD    = 17'($urandom);
      PCD       = 12'($urandom);
      PCPlus1D  = 12'($urandom);
      StallE    = ($urandom_range(0, 9) < 3);
      FlushE    = ($urandom_range(0, 9) < 1);
      RegWriteW = ($urandom_range(0, 9) < 6);
      RdW       = 4'($urandom);
      ResultW   = 16'($urandom);
      cand = model(InstrD, PCD, PCPlus1D, RegWriteW, RdW, ResultW);
      if (FlushE) exp_e = '0;
      else if (!StallE) exp_e = cand;
      if (RegWriteW && RdW != 0) ref_regs[RdW] = ResultW;
      tick();
      total_cnt++;
      if (obs() !== exp_e) $display("FAIL random step %0d got %h want %h", n, obs(), exp_e);
      else pass_cnt++;
    end
    StallE = 0; FlushE = 0; RegWriteW = 0;
  endtask

  initial begin
    do_reset();
    test_reset();
    test_add();
    test_beq();
    test_wb_read();
    test_pipeline_ctrl();
    test_corners();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
